// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter: shares one barrier gate between entry and exit requests,
// owns the occupancy count, and aborts a grant if no car passes in time.
// Optional build macro PARK_RR_EN: round-robin tie-break between entry and exit
// (default build uses fixed exit priority and has no last-grant register).
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | gate closed, arbitrating pending/new requests
// ST_GRANT_IN| gate open for entry, waiting for S or timeout
// ST_GRANT_OUT| gate open for exit, waiting for R or timeout
// ST_CLOSE   | gate held closed for CLOSE_CYC cycles after a grant
module parking_gate_arbiter #(
  parameter int unsigned CAPACITY  = 7,
  parameter int unsigned CNT_W     = 3,
  parameter logic [23:0] TIMEOUT   = 24'd12_000_000,
  parameter logic [15:0] CLOSE_CYC = 16'd1200
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             req_in,
  input  logic             req_out,
  input  logic             S,
  input  logic             R,
  output logic             gate_open,
  output logic             grant_in,
  output logic             grant_out,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             reject,
  output logic             timeout
);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT_IN, ST_GRANT_OUT, ST_CLOSE} state_t;

  localparam logic [CNT_W-1:0] CAP_C   = CNT_W'(CAPACITY);
  localparam logic [23:0]      TO_LAST = TIMEOUT - 24'd1;
  localparam logic [23:0]      CL_LAST = {8'd0, CLOSE_CYC - 16'd1};

  state_t           state_q, state_d;
  logic [23:0]      timer_q, timer_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pend_in_q, pend_in_d;
  logic             pend_out_q, pend_out_d;
  logic             reject_q, reject_d;
  logic             timeout_q, timeout_d;
  logic             gate_open_q, gate_open_d;
  logic             grant_in_q, grant_in_d;
  logic             grant_out_q, grant_out_d;
  logic             eff_in, eff_out, ok_in, ok_out, pick_in, pick_out;
`ifdef PARK_RR_EN
  logic             last_out_q, last_out_d;
`endif

  assign gate_open = gate_open_q;
  assign grant_in  = grant_in_q;
  assign grant_out = grant_out_q;
  assign count     = count_q;
  assign reject    = reject_q;
  assign timeout   = timeout_q;
  assign full      = (count_q == CAP_C);
  assign empty     = (count_q == '0);

  // State register and all registered outputs; reset closes the gate at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      count_q     <= '0;
      pend_in_q   <= 1'b0;
      pend_out_q  <= 1'b0;
      reject_q    <= 1'b0;
      timeout_q   <= 1'b0;
      gate_open_q <= 1'b0;
      grant_in_q  <= 1'b0;
      grant_out_q <= 1'b0;
`ifdef PARK_RR_EN
      last_out_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      count_q     <= count_d;
      pend_in_q   <= pend_in_d;
      pend_out_q  <= pend_out_d;
      reject_q    <= reject_d;
      timeout_q   <= timeout_d;
      gate_open_q <= gate_open_d;
      grant_in_q  <= grant_in_d;
      grant_out_q <= grant_out_d;
`ifdef PARK_RR_EN
      last_out_q  <= last_out_d;
`endif
    end
  end

  // Next-state logic: arbitration, pass/timeout handling, count update.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + 24'd1;
    count_d    = count_q;
    pend_in_d  = pend_in_q | req_in;
    pend_out_d = pend_out_q | req_out;
    reject_d   = 1'b0;
    timeout_d  = 1'b0;
    eff_in     = 1'b0;
    eff_out    = 1'b0;
    ok_in      = 1'b0;
    ok_out     = 1'b0;
    pick_in    = 1'b0;
    pick_out   = 1'b0;
`ifdef PARK_RR_EN
    last_out_d = last_out_q;
`endif
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        eff_in  = pend_in_q | req_in;
        eff_out = pend_out_q | req_out;
        ok_in   = eff_in & ~full;
        ok_out  = eff_out & ~empty;
        // A refused side is dropped without blocking the other side.
        if (eff_out && empty) begin
          reject_d   = 1'b1;
          pend_out_d = 1'b0;
        end
        if (eff_in && full) begin
          reject_d  = 1'b1;
          pend_in_d = 1'b0;
        end
`ifdef PARK_RR_EN
        pick_out = ok_out & (~ok_in | ~last_out_q);
`else
        pick_out = ok_out;
`endif
        pick_in = ok_in & ~pick_out;
        if (pick_out) begin
          state_d    = ST_GRANT_OUT;
          pend_out_d = 1'b0;
`ifdef PARK_RR_EN
          last_out_d = 1'b1;
`endif
        end else if (pick_in) begin
          state_d   = ST_GRANT_IN;
          pend_in_d = 1'b0;
`ifdef PARK_RR_EN
          last_out_d = 1'b0;
`endif
        end
      end
      ST_GRANT_IN: begin
        // A pass on the terminal-count cycle beats the timeout.
        if (S) begin
          if (count_q != CAP_C) count_d = count_q + CNT_W'(1);
          state_d = ST_CLOSE;
          timer_d = '0;
        end else if (timer_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_CLOSE;
          timer_d   = '0;
        end
      end
      ST_GRANT_OUT: begin
        if (R) begin
          if (count_q != '0) count_d = count_q - CNT_W'(1);
          state_d = ST_CLOSE;
          timer_d = '0;
        end else if (timer_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_CLOSE;
          timer_d   = '0;
        end
      end
      ST_CLOSE: begin
        if (timer_q == CL_LAST) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state so gate/grant flops track the state register.
  always_comb begin
    gate_open_d = 1'b0;
    grant_in_d  = 1'b0;
    grant_out_d = 1'b0;
    if (state_d == ST_GRANT_IN) begin
      gate_open_d = 1'b1;
      grant_in_d  = 1'b1;
    end else if (state_d == ST_GRANT_OUT) begin
      gate_open_d = 1'b1;
      grant_out_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Self-checking bench for parking_gate_arbiter; transaction-level reference model.
module tb_parking_gate_arbiter;

  localparam int CAP = 7;
  localparam int TO  = 20;
  localparam int CC  = 5;
`ifdef PARK_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic       CLK;
  logic       RST_N;
  logic       req_in, req_out, S, R;
  logic       gate_open, grant_in, grant_out, full, empty, reject, timeout;
  logic [2:0] count;

  int n_checks;
  int n_fail;
  int m_count;
  bit m_last_out;

  parking_gate_arbiter #(
    .CAPACITY (CAP),
    .CNT_W    (3),
    .TIMEOUT  (24'd20),
    .CLOSE_CYC(16'd5)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .req_in   (req_in),
    .req_out  (req_out),
    .S        (S),
    .R        (R),
    .gate_open(gate_open),
    .grant_in (grant_in),
    .grant_out(grant_out),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .reject   (reject),
    .timeout  (timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [9:0] obs();
    return {gate_open, grant_in, grant_out, reject, timeout, full, empty, count};
  endfunction

  // Expected output vector; full/empty/count come from the model occupancy.
  function automatic logic [9:0] ev(input bit g, input bit gi, input bit go,
                                    input bit rj, input bit to);
    return {g, gi, go, rj, to, (m_count == CAP), (m_count == 0), 3'(m_count)};
  endfunction

  // Arbitration rules: refuse entry when full, exit when empty; tie -> exit,
  // or under round-robin the side not granted last. side/left: -1 none, 0 in, 1 out.
  task automatic decide(input bit wi, input bit wo, output int side,
                        output bit rej, output int left);
    bit ok_i, ok_o, out_first;
    ok_i = wi && (m_count < CAP);
    ok_o = wo && (m_count > 0);
    rej  = (wi && !ok_i) || (wo && !ok_o);
    out_first = RR_MODE ? !m_last_out : 1'b1;
    side = -1;
    left = -1;
    if (ok_i && ok_o) begin
      side = out_first ? 1 : 0;
      left = out_first ? 0 : 1;
    end else if (ok_o) side = 1;
    else if (ok_i) side = 0;
    if (side >= 0) m_last_out = (side == 1);
  endtask

  // Hold a grant for a random time, then pass (mode 1), time out (mode 2) or either (0).
  task automatic serve(input int side, input int mode);
    int delay;
    bit pass;
    logic [9:0] exp_v;
    pass  = (mode == 1) || (mode == 0 && $urandom_range(0, 3) != 0);
    delay = $urandom_range(0, TO - 1);
    for (int i = 0; i < delay; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        if (side == 0) R = 1'b1; else S = 1'b1;
      end
      tick();
      S = 1'b0;
      R = 1'b0;
    end
    exp_v = ev(1, side == 0, side == 1, 0, 0);
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL grant_hold: got %b want %b (delay %0d)", obs(), exp_v, delay);
    end
    if (pass) begin
      if (side == 0) S = 1'b1; else R = 1'b1;
      tick();
      S = 1'b0;
      R = 1'b0;
      if (side == 0 && m_count < CAP) m_count++;
      else if (side == 1 && m_count > 0) m_count--;
      exp_v = ev(0, 0, 0, 0, 0);
      n_checks++;
      if (obs() !== exp_v) begin
        n_fail++;
        $display("FAIL pass_close: got %b want %b", obs(), exp_v);
      end
    end else begin
      repeat (TO - 1 - delay) tick();
      exp_v = ev(1, side == 0, side == 1, 0, 0);
      n_checks++;
      if (obs() !== exp_v) begin
        n_fail++;
        $display("FAIL pre_timeout: got %b want %b", obs(), exp_v);
      end
      tick();
      exp_v = ev(0, 0, 0, 0, 1);
      n_checks++;
      if (obs() !== exp_v) begin
        n_fail++;
        $display("FAIL timeout_pulse: got %b want %b", obs(), exp_v);
      end
    end
  endtask

  // One request (entry, exit or both) from idle, served to completion.
  task automatic run_txn(input bit wi, input bit wo, input int mode);
    int side, left;
    bit rej;
    logic [9:0] exp_v;
    decide(wi, wo, side, rej, left);
    req_in  = wi;
    req_out = wo;
    tick();
    req_in  = 1'b0;
    req_out = 1'b0;
    exp_v = ev(side >= 0, side == 0, side == 1, rej, 0);
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL request_decision: got %b want %b (in %0b out %0b)", obs(), exp_v, wi, wo);
    end
    while (side >= 0) begin
      serve(side, mode);
      repeat (CC) tick();
      exp_v = ev(0, 0, 0, 0, 0);
      n_checks++;
      if (obs() !== exp_v) begin
        n_fail++;
        $display("FAIL close_hold: got %b want %b", obs(), exp_v);
      end
      if (left >= 0) begin
        decide(left == 0, left == 1, side, rej, left);
        tick();
        exp_v = ev(side >= 0, side == 0, side == 1, rej, 0);
        n_checks++;
        if (obs() !== exp_v) begin
          n_fail++;
          $display("FAIL pending_served: got %b want %b", obs(), exp_v);
        end
      end else begin
        side = -1;
      end
    end
  endtask

  task automatic test_reset();
    logic [9:0] exp_v;
    RST_N = 1'b0;
    req_in = 1'b0; req_out = 1'b0; S = 1'b0; R = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    m_count    = 0;
    m_last_out = 1'b0;
    exp_v = ev(0, 0, 0, 0, 0);
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL reset_state: got %b want %b", obs(), exp_v);
    end
    RST_N = 1'b1;
    tick();
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b want %b", obs(), exp_v);
    end
  endtask

  task automatic test_basic();
    logic [9:0] exp_v;
    req_in = 1'b1;
    tick();
    req_in = 1'b0;
    m_last_out = 1'b0;
    exp_v = ev(1, 1, 0, 0, 0);
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL basic_grant: got %b want %b", obs(), exp_v);
    end
    tick();
    S = 1'b1;
    tick();
    S = 1'b0;
    m_count = 1;
    exp_v = ev(0, 0, 0, 0, 0);
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL basic_pass: got %b want %b", obs(), exp_v);
    end
    tick();
    req_out = 1'b1;
    tick();
    req_out = 1'b0;
    repeat (CC - 2) tick();
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL close_len: got %b want %b", obs(), exp_v);
    end
    tick();
    m_last_out = 1'b1;
    exp_v = ev(1, 0, 1, 0, 0);
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL pending_after_close: got %b want %b", obs(), exp_v);
    end
    serve(1, 1);
    repeat (CC) tick();
  endtask

  task automatic test_fill();
    logic [9:0] exp_v;
    while (m_count < CAP) run_txn(1, 0, 1);
    run_txn(1, 0, 1);
    tick();
    exp_v = ev(0, 0, 0, 0, 0);
    n_checks++;
    if (obs() !== exp_v || full !== 1'b1) begin
      n_fail++;
      $display("FAIL full_reject_width: got %b want %b", obs(), exp_v);
    end
  endtask

  task automatic test_empty();
    logic [9:0] exp_v;
    test_reset();
    run_txn(0, 1, 1);
    tick();
    exp_v = ev(0, 0, 0, 0, 0);
    n_checks++;
    if (obs() !== exp_v || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_reject_width: got %b want %b", obs(), exp_v);
    end
  endtask

  task automatic test_ignored();
    logic [9:0] exp_v;
    S = 1'b1;
    tick();
    S = 1'b0;
    R = 1'b1;
    tick();
    R = 1'b0;
    exp_v = ev(0, 0, 0, 0, 0);
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL idle_pass_ignored: got %b want %b", obs(), exp_v);
    end
  endtask

  task automatic test_tie();
    test_reset();
    repeat (3) run_txn(1, 0, 1);
    run_txn(1, 1, 1);
    run_txn(0, 1, 1);
    run_txn(1, 1, 1);
  endtask

  task automatic test_reset_mid();
    logic [9:0] exp_v;
    test_reset();
    run_txn(1, 0, 1);
    run_txn(1, 0, 1);
    req_out = 1'b1;
    tick();
    req_out = 1'b0;
    exp_v = ev(1, 0, 1, 0, 0);
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL rm_grant: got %b want %b", obs(), exp_v);
    end
    req_in = 1'b1;
    tick();
    req_in = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    m_count    = 0;
    m_last_out = 1'b0;
    exp_v = ev(0, 0, 0, 0, 0);
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL async_reset: got %b want %b", obs(), exp_v);
    end
    #3 RST_N = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL pending_cleared: got %b want %b", obs(), exp_v);
    end
  endtask

  task automatic test_random();
    bit wi, wo;
    for (int n = 0; n < 60; n++) begin
      wi = $urandom_range(0, 1) == 1;
      wo = $urandom_range(0, 1) == 1;
      if (!wi && !wo) wi = 1'b1;
      run_txn(wi, wo, 0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_fill();
    test_empty();
    test_reset();
    run_txn(1, 0, 2);
    test_ignored();
    test_tie();
    test_reset_mid();
    test_random();
    test_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
